pipelined_csa_multiplier: RTL and testbench



---
 rtl/pipelined_csa_multiplier.sv | 184 ++++++++++++++++++
 tb/tb_pipelined_csa_multiplier.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipelined_csa_multiplier.sv
// Four-stage WIDTH x WIDTH multiplier: operand register, partial CSA reduction,
// CSA tree completion to sum/carry, carry-propagate add. Global stall, no bubble squeeze.
module pipelined_csa_multiplier #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned TAG_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic                 in_signed,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   out_product,
  output logic [TAG_W-1:0]     out_tag,
  output logic                 busy
);

  localparam int unsigned PW      = 2 * WIDTH;
  localparam int unsigned NPP     = WIDTH + 1;
  localparam int unsigned MID     = (WIDTH + 2) / 3 + 1;
  localparam int unsigned MAX_LVL = 12;

  typedef logic [PW-1:0] row_t;
  typedef logic [NPP-1:0][PW-1:0] rows_t;

  // Applies 3:2 levels until at most `target` rows remain; carries out of the
  // top bit fall off, which is exact modulo 2^PW.
  function automatic rows_t csa_reduce(input rows_t rows_in, input int unsigned n_in,
                                       input int unsigned target);
    rows_t       cur;
    rows_t       nxt;
    int unsigned n;
    int unsigned m;
    cur = rows_in;
    n   = n_in;
    for (int unsigned lvl = 0; lvl < MAX_LVL; lvl++) begin
      if (n > target) begin
        nxt = '0;
        m   = 0;
        for (int unsigned g = 0; g < NPP / 3; g++) begin
          if (3 * g + 2 < n) begin
            nxt[m]     = cur[3*g] ^ cur[3*g+1] ^ cur[3*g+2];
            nxt[m + 1] = ((cur[3*g] & cur[3*g+1]) | (cur[3*g] & cur[3*g+2]) |
                          (cur[3*g+1] & cur[3*g+2])) << 1;
            m = m + 2;
          end
        end
        for (int unsigned r = 0; r < NPP; r++) begin
          if (r >= (n / 3) * 3 && r < n) begin
            nxt[m] = cur[r];
            m = m + 1;
          end
        end
        cur = nxt;
        n   = m;
      end
    end
    return cur;
  endfunction

  logic                  adv;
  logic                  accept;

  logic                  s1_valid;
  logic [WIDTH-1:0]      s1_a;
  logic [WIDTH-1:0]      s1_b;
  logic                  s1_signed;
  logic [TAG_W-1:0]      s1_tag;

  logic                  s2_valid;
  logic [MID-1:0][PW-1:0] s2_rows;
  logic [TAG_W-1:0]      s2_tag;

  logic                  s3_valid;
  logic [1:0][PW-1:0]    s3_rows;
  logic [TAG_W-1:0]      s3_tag;

  logic                  s4_valid;
  logic [PW-1:0]         s4_product;
  logic [TAG_W-1:0]      s4_tag;

  row_t                  a_ext;
  rows_t                 pp;
  rows_t                 mid_full;
  rows_t                 s3_in;
  rows_t                 fin_full;
  logic [MID-1:0][PW-1:0] s2_d;
  logic [1:0][PW-1:0]    s3_d;

  assign adv      = ~s4_valid | out_ready;
  assign in_ready = adv & ~flush;
  assign accept   = in_valid & in_ready;

  // Signed mode: rows are sign-extended and the multiplier's sign row is
  // negated as ~x plus a correction row holding 2^(WIDTH-1).
  always_comb begin
    a_ext = s1_signed ? {{WIDTH{s1_a[WIDTH-1]}}, s1_a} : {{WIDTH{1'b0}}, s1_a};
    pp    = '0;
    for (int unsigned j = 0; j < WIDTH; j++) begin
      if (s1_b[j]) begin
        if (s1_signed && (j == WIDTH - 1)) begin
          pp[j] = (~a_ext) << j;
        end else begin
          pp[j] = a_ext << j;
        end
      end
    end
    pp[WIDTH] = (s1_signed && s1_b[WIDTH-1]) ? (row_t'(1) << (WIDTH - 1)) : '0;
  end

  always_comb begin
    mid_full = csa_reduce(pp, NPP, MID);
    s2_d     = '0;
    for (int unsigned r = 0; r < MID; r++) begin
      s2_d[r] = mid_full[r];
    end
  end

  always_comb begin
    s3_in = '0;
    for (int unsigned r = 0; r < MID; r++) begin
      s3_in[r] = s2_rows[r];
    end
    fin_full = csa_reduce(s3_in, MID, 2);
    s3_d     = '0;
    for (int unsigned r = 0; r < 2; r++) begin
      s3_d[r] = fin_full[r];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s1_a       <= '0;
      s1_b       <= '0;
      s1_signed  <= 1'b0;
      s1_tag     <= '0;
      s2_valid   <= 1'b0;
      s2_rows    <= '0;
      s2_tag     <= '0;
      s3_valid   <= 1'b0;
      s3_rows    <= '0;
      s3_tag     <= '0;
      s4_valid   <= 1'b0;
      s4_product <= '0;
      s4_tag     <= '0;
    end else begin
      if (adv) begin
        s1_valid   <= accept;
        s1_a       <= in_a;
        s1_b       <= in_b;
        s1_signed  <= in_signed;
        s1_tag     <= in_tag;
        s2_valid   <= s1_valid;
        s2_rows    <= s2_d;
        s2_tag     <= s1_tag;
        s3_valid   <= s2_valid;
        s3_rows    <= s3_d;
        s3_tag     <= s2_tag;
        s4_valid   <= s3_valid;
        s4_product <= s3_rows[0] + s3_rows[1];
        s4_tag     <= s3_tag;
      end
      // Flush kills valid bits only; data registers may keep stale contents.
      if (flush) begin
        s1_valid <= 1'b0;
        s2_valid <= 1'b0;
        s3_valid <= 1'b0;
        s4_valid <= 1'b0;
      end
    end
  end

  assign out_valid   = s4_valid;
  assign out_product = s4_product;
  assign out_tag     = s4_tag;
  assign busy        = s1_valid | s2_valid | s3_valid | s4_valid;

endmodule

// File: tb/tb_pipelined_csa_multiplier.sv
// Bench for pipelined_csa_multiplier: directed corners, randomized backpressure stream,
// flush, mid-operation reset and a WIDTH sweep against an arithmetic reference.
module tb_pipelined_csa_multiplier;

  localparam int unsigned W  = 32;
  localparam int unsigned TW = 4;

  typedef struct packed {
    logic [TW-1:0]  tag;
    logic [2*W-1:0] prod;
  } res_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [W-1:0]     in_a;
  logic [W-1:0]     in_b;
  logic             in_signed;
  logic [TW-1:0]    in_tag;
  logic             out_valid;
  logic             out_ready;
  logic [2*W-1:0]   out_product;
  logic [TW-1:0]    out_tag;
  logic             busy;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  logic        sweep_go = 1'b0;
  res_t        expq[$];

  pipelined_csa_multiplier #(.WIDTH(W), .TAG_W(TW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_a        (in_a),
    .in_b        (in_b),
    .in_signed   (in_signed),
    .in_tag      (in_tag),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_product (out_product),
    .out_tag     (out_tag),
    .busy        (busy)
  );

  task automatic check(input string tag, input logic [159:0] got, input logic [159:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Exact product: extend both operands to 2W bits and multiply modulo 2^2W.
  function automatic logic [2*W-1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b,
                                              input logic s);
    logic [2*W-1:0] ea;
    logic [2*W-1:0] eb;
    ea = s ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
    eb = s ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
    return ea * eb;
  endfunction

  task automatic run_one(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic s, input logic [TW-1:0] t, input logic [2*W-1:0] expp);
    @(negedge clk);
    in_a = a; in_b = b; in_signed = s; in_tag = t;
    in_valid = 1'b1; out_ready = 1'b1; flush = 1'b0;
    #1 check({name, "_rdy"}, in_ready, 1'b1);
    for (int unsigned k = 1; k <= 4; k++) begin
      @(negedge clk);
      in_valid = 1'b0;
      check($sformatf("%s_v%0d", name, k), out_valid, (k == 4));
    end
    check({name, "_prod"}, out_product, expp);
    check({name, "_tag"}, out_tag, t);
  endtask

  // Parameter sweep: each width streams continuously with out_ready held high.
  for (genvar k = 0; k < 3; k++) begin : g_sweep
    localparam int unsigned SW   = (k == 0) ? 4 : ((k == 1) ? 8 : 64);
    localparam int unsigned NOPS = (k == 0) ? 512 : 300;
    logic [SW-1:0]     a;
    logic [SW-1:0]     b;
    logic              sg;
    logic              iv = 1'b0;
    logic              ir;
    logic              ov;
    logic [2*SW-1:0]   prod;
    logic [3:0]        tg;
    logic [3:0]        otg;
    logic              bz;
    logic              fin = 1'b0;
    logic [2*SW-1:0]   ea;
    logic [2*SW-1:0]   eb;
    logic [2*SW+3:0]   q[$];
    int unsigned       sent = 0;
    int unsigned       seen = 0;

    pipelined_csa_multiplier #(.WIDTH(SW), .TAG_W(4)) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .flush       (1'b0),
      .in_valid    (iv),
      .in_ready    (ir),
      .in_a        (a),
      .in_b        (b),
      .in_signed   (sg),
      .in_tag      (tg),
      .out_valid   (ov),
      .out_ready   (1'b1),
      .out_product (prod),
      .out_tag     (otg),
      .busy        (bz)
    );

    initial begin
      a = '0; b = '0; sg = 1'b0; tg = '0;
      wait (sweep_go);
      for (int unsigned cyc = 0; cyc < NOPS + 100 && seen < NOPS; cyc++) begin
        @(negedge clk);
        if (ov) begin
          seen++;
          if (q.size() == 0) check($sformatf("w%0d_extra", SW), 1'b1, 1'b0);
          else check($sformatf("w%0d_prod", SW), {otg, prod}, q.pop_front());
        end
        if (sent < NOPS) begin
          if (k == 0) begin
            a  = SW'(sent);
            b  = SW'(sent >> 4);
            sg = sent[8];
          end else begin
            a  = SW'({$urandom(), $urandom()});
            b  = SW'({$urandom(), $urandom()});
            sg = 1'($urandom_range(0, 1));
          end
          tg = 4'(sent);
          iv = 1'b1;
        end else begin
          iv = 1'b0;
        end
        #1;
        if (iv && ir) begin
          ea = sg ? {{SW{a[SW-1]}}, a} : {{SW{1'b0}}, a};
          eb = sg ? {{SW{b[SW-1]}}, b} : {{SW{1'b0}}, b};
          q.push_back({tg, ea * eb});
          sent++;
        end
      end
      check($sformatf("w%0d_count", SW), seen, NOPS);
      @(negedge clk);
      check($sformatf("w%0d_busy", SW), bz, 1'b0);
      fin = 1'b1;
    end
  end

  initial begin
    res_t        r;
    int unsigned issued;
    int unsigned got;
    logic        acc;
    logic        saw;

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0;
    in_signed = 1'b0; in_tag = '0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_product", out_product, '0);
    check("rst_tag", out_tag, '0);
    check("rst_in_ready", in_ready, 1'b1);

    run_one("u_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 4'd5, 64'hFFFF_FFFE_0000_0001);
    run_one("s_m1", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 4'd1, 64'h0000_0000_0000_0001);
    run_one("s_min", 32'h8000_0000, 32'h8000_0000, 1'b1, 4'd2, 64'h4000_0000_0000_0000);
    run_one("s_m7x3", 32'hFFFF_FFF9, 32'd3, 1'b1, 4'd3, 64'hFFFF_FFFF_FFFF_FFEB);

    // Randomized stream with pseudo-random backpressure.
    issued = 0; got = 0; acc = 1'b1;
    for (int unsigned cyc = 0; cyc < 400 && got < 20; cyc++) begin
      @(negedge clk);
      if (acc || !in_valid) begin
        if (issued < 20) begin
          in_a = $urandom(); in_b = $urandom();
          in_signed = 1'($urandom_range(0, 1));
          in_tag = issued[3:0];
          in_valid = 1'b1;
        end else begin
          in_valid = 1'b0;
        end
      end
      acc = 1'b0;
      out_ready = 1'($urandom_range(0, 1));
      #1;
      if (out_valid) check("bp_ready", in_ready, out_ready);
      if (out_valid && out_ready) begin
        got++;
        if (expq.size() == 0) begin
          check("bp_extra", 1'b1, 1'b0);
        end else begin
          r = expq.pop_front();
          check("bp_prod", out_product, r.prod);
          check("bp_tag", out_tag, r.tag);
        end
      end
      if (in_valid && in_ready) begin
        r.tag  = in_tag;
        r.prod = ref_mul(in_a, in_b, in_signed);
        expq.push_back(r);
        issued++;
        acc = 1'b1;
      end
    end
    check("bp_count", got, 20);
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    saw = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid) saw = 1'b1;
    end
    check("bp_dup", saw, 1'b0);
    check("bp_q_empty", expq.size(), 0);

    // Flush: three ops, one idle cycle, then flush alongside a fresh offer.
    for (int unsigned i = 0; i < 3; i++) begin
      @(negedge clk);
      in_a = $urandom(); in_b = $urandom(); in_signed = i[0];
      in_tag = 4'(8 + i); in_valid = 1'b1;
    end
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    in_a = 32'd7; in_b = 32'd9; in_tag = 4'hF; in_valid = 1'b1; flush = 1'b1;
    #1;
    check("fl_in_ready", in_ready, 1'b0);
    check("fl_presented", out_valid, 1'b1);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    check("fl_busy", busy, 1'b0);
    check("fl_valid", out_valid, 1'b0);
    saw = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) saw = 1'b1;
    end
    check("fl_drop", saw, 1'b0);
    run_one("fl_after", 32'd1234567, 32'hFFFF_FF00, 1'b1, 4'hA,
            ref_mul(32'd1234567, 32'hFFFF_FF00, 1'b1));

    // Reset while an operation is in flight.
    @(negedge clk);
    in_a = 32'd11; in_b = 32'd13; in_signed = 1'b0; in_tag = 4'h6; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("rst_pre_busy", busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_mid_busy", busy, 1'b0);
    check("rst_mid_prod", out_product, '0);
    @(negedge clk);
    rst_n = 1'b1;
    saw = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) saw = 1'b1;
    end
    check("rst_drop", saw, 1'b0);

    sweep_go = 1'b1;
    for (int unsigned i = 0; i < 3000 && !(g_sweep[0].fin && g_sweep[1].fin && g_sweep[2].fin);
         i++) begin
      @(negedge clk);
    end
    check("sweep_done", {g_sweep[0].fin, g_sweep[1].fin, g_sweep[2].fin}, 3'b111);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
